// File: rtl/arbitro_vc_if.sv
// ----------------------------------------------------------------------------
// arbitro_vc_if
//   Bundle between the VC round-robin arbiter and its surroundings: the
//   flow-control FSM (enable, error_in), the two first-word-fall-through
//   VC FIFOs (empty/data/pop) and the two destination FIFOs (almost_full,
//   push, shared d_data). It also carries the status outputs.
//
//   modport slave  : the arbiter's view (flags and head words in, strobes out)
//   modport master : the environment's view (drives flags, observes strobes)
//
//   DATA_WIDTH and COUNT_WIDTH must match the arbiter instance that uses it.
// ----------------------------------------------------------------------------
interface arbitro_vc_if #(
    parameter int DATA_WIDTH  = 6,
    parameter int COUNT_WIDTH = 8
);
    logic                   enable;
    logic                   error_in;
    logic                   vc0_empty;
    logic                   vc1_empty;
    logic [DATA_WIDTH-1:0]  vc0_data;
    logic [DATA_WIDTH-1:0]  vc1_data;
    logic                   d0_almost_full;
    logic                   d1_almost_full;
    logic                   vc0_pop;
    logic                   vc1_pop;
    logic                   d0_push;
    logic                   d1_push;
    logic [DATA_WIDTH-1:0]  d_data;
    logic                   last_grant;
    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] word_count;

    modport slave (
        input  enable, error_in,
        input  vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data,
        output last_grant, state, word_count
    );

    modport master (
        output enable, error_in,
        output vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data,
        input  last_grant, state, word_count
    );
endinterface

// File: rtl/arbitro_vc.sv
// ----------------------------------------------------------------------------
// arbitro_vc
//   Round-robin arbiter/router from two FWFT virtual-channel FIFOs (VC0, VC1)
//   to two destination FIFOs (D0, D1). A VC is eligible when it holds a word
//   and the destination named by that word's MSB is not almost full. At most
//   one VC is popped per cycle (combinational pop strobe); the popped word is
//   registered and pushed into its destination on the following cycle.
//   Ties go to the VC that was not granted last.
//
//   Ports:
//     clk    : single clock, rising edge
//     reset  : asynchronous, active-low; clears all state immediately
//     bus    : arbitro_vc_if.slave
//              in  enable, error_in, vc*_empty, vc*_data, d*_almost_full
//              out vc*_pop (comb), d*_push / d_data (reg), last_grant,
//                  state (0 IDLE, 1 RUN, 2 HALT), word_count (wraps)
// ----------------------------------------------------------------------------
module arbitro_vc #(
    parameter int DATA_WIDTH  = 6,
    parameter int COUNT_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    arbitro_vc_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int MSB = DATA_WIDTH - 1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_last_grant;
    logic [DATA_WIDTH-1:0]  r_d_data;
    logic                   r_d0_push;
    logic                   r_d1_push;
    logic [COUNT_WIDTH-1:0] r_word_count;

    logic                   w_vc0_elig;
    logic                   w_vc1_elig;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_gnt_any;
    logic [DATA_WIDTH-1:0]  w_gnt_data;

    // A head word is only blocked by the destination it actually targets.
    assign w_vc0_elig = !bus.vc0_empty &&
                        !(bus.vc0_data[MSB] ? bus.d1_almost_full : bus.d0_almost_full);
    assign w_vc1_elig = !bus.vc1_empty &&
                        !(bus.vc1_data[MSB] ? bus.d1_almost_full : bus.d0_almost_full);

    // Next-state and grant decode.
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;

        if (bus.error_in) begin
            w_state_next = ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.enable)  w_state_next = ST_RUN;
                ST_RUN:  if (!bus.enable) w_state_next = ST_IDLE;
                ST_HALT: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end

        // enable/error_in gate the grant in the same cycle they change.
        if (r_state == ST_RUN && bus.enable && !bus.error_in) begin
            if (w_vc0_elig && w_vc1_elig) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = w_vc0_elig;
                w_gnt1 = w_vc1_elig;
            end
        end
    end

    assign w_gnt_any  = w_gnt0 || w_gnt1;
    assign w_gnt_data = w_gnt1 ? bus.vc1_data : bus.vc0_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_d_data     <= '0;
            r_d0_push    <= 1'b0;
            r_d1_push    <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_d0_push <= w_gnt_any && !w_gnt_data[MSB];
            r_d1_push <= w_gnt_any &&  w_gnt_data[MSB];
            if (w_gnt_any) begin
                r_d_data     <= w_gnt_data;
                r_last_grant <= w_gnt1;
            end
            if (r_d0_push || r_d1_push) begin
                r_word_count <= r_word_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Pops are combinational; the explicit reset term keeps them low while
    // reset is asserted regardless of what the FIFOs present.
    assign bus.vc0_pop    = w_gnt0 && reset;
    assign bus.vc1_pop    = w_gnt1 && reset;
    assign bus.d0_push    = r_d0_push;
    assign bus.d1_push    = r_d1_push;
    assign bus.d_data     = r_d_data;
    assign bus.last_grant = r_last_grant;
    assign bus.state      = r_state;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_arbitro_vc.sv
// ----------------------------------------------------------------------------
// tb_arbitro_vc
//   Bench for arbitro_vc. The VC FIFOs are modelled as queues presenting
//   their head word; a behavioural model tracks mode, last winner, the word in
//   flight and the push count, and keeps the expected contents of D0/D1.
// ----------------------------------------------------------------------------
module tb_arbitro_vc;

    localparam int DW = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbitro_vc_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    arbitro_vc #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Environment FIFOs and what actually reached each destination.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] d0_log[$];
    logic [DW-1:0] d1_log[$];

    // Reference model: 0 idle, 1 run, 2 halt.
    int            m_state;
    logic          m_last;
    logic          m_push0;
    logic          m_push1;
    logic [DW-1:0] m_data;
    int            m_count;
    logic [DW-1:0] m_d0_log[$];
    logic [DW-1:0] m_d1_log[$];

    typedef struct {
        logic e0, e1, m0, m1, af0, af1;
        logic p0, p1, lg, d0p, d1p;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic int model_grant(input logic en, input logic err,
                                       input logic af0, input logic af1);
        bit e0, e1;
        if (m_state != 1 || !en || err) return -1;
        e0 = (q0.size() > 0) && !(q0[0][DW-1] ? af1 : af0);
        e1 = (q1.size() > 0) && !(q1[0][DW-1] ? af1 : af0);
        if (e0 && e1) return m_last ? 0 : 1;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic drive_vc();
        bus.vc0_empty = (q0.size() == 0);
        bus.vc1_empty = (q1.size() == 0);
        bus.vc0_data  = (q0.size() > 0) ? q0[0] : '0;
        bus.vc1_data  = (q1.size() > 0) ? q1[0] : '0;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic en, input logic err, input logic af0, input logic af1);
        int            g;
        logic          p0, p1;
        logic [DW-1:0] w;
        bus.enable         = en;
        bus.error_in       = err;
        bus.d0_almost_full = af0;
        bus.d1_almost_full = af1;
        drive_vc();
        #2;
        g  = model_grant(en, err, af0, af1);
        p0 = bus.vc0_pop;
        p1 = bus.vc1_pop;
        check("vc0_pop", 32'(p0), 32'(g == 0));
        check("vc1_pop", 32'(p1), 32'(g == 1));

        if (m_push0 || m_push1) m_count = (m_count + 1) % (1 << CW);
        m_push0 = 1'b0;
        m_push1 = 1'b0;
        if (g >= 0) begin
            w      = (g == 0) ? q0[0] : q1[0];
            m_data = w;
            m_last = (g == 1);
            if (w[DW-1]) begin m_push1 = 1'b1; m_d1_log.push_back(w); end
            else         begin m_push0 = 1'b1; m_d0_log.push_back(w); end
        end
        if (err)                  m_state = 2;
        else if (m_state == 0)    m_state = en ? 1 : 0;
        else if (m_state == 1)    m_state = en ? 1 : 0;
        else                      m_state = 0;

        @(posedge clk);
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        #1;
        if (bus.d0_push) d0_log.push_back(bus.d_data);
        if (bus.d1_push) d1_log.push_back(bus.d_data);
        check("state",      32'(bus.state),      32'(m_state));
        check("last_grant", 32'(bus.last_grant), 32'(m_last));
        check("d0_push",    32'(bus.d0_push),    32'(m_push0));
        check("d1_push",    32'(bus.d1_push),    32'(m_push1));
        check("d_data",     32'(bus.d_data),     32'(m_data));
        check("word_count", 32'(bus.word_count), 32'(m_count));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_push0 || m_push1) && n < budget) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic compare_logs(input string name);
        check({name, "_d0_len"}, 32'(d0_log.size()), 32'(m_d0_log.size()));
        check({name, "_d1_len"}, 32'(d1_log.size()), 32'(m_d1_log.size()));
        for (int i = 0; i < d0_log.size() && i < m_d0_log.size(); i++)
            if (d0_log[i] !== m_d0_log[i]) check({name, "_d0_word"}, 32'(d0_log[i]), 32'(m_d0_log[i]));
        for (int i = 0; i < d1_log.size() && i < m_d1_log.size(); i++)
            if (d1_log[i] !== m_d1_log[i]) check({name, "_d1_word"}, 32'(d1_log[i]), 32'(m_d1_log[i]));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_state"}, 32'(bus.state),      32'd0);
        check({name, "_lg"},    32'(bus.last_grant), 32'd1);
        check({name, "_ddata"}, 32'(bus.d_data),     32'd0);
        check({name, "_push0"}, 32'(bus.d0_push),    32'd0);
        check({name, "_push1"}, 32'(bus.d1_push),    32'd0);
        check({name, "_pop0"},  32'(bus.vc0_pop),    32'd0);
        check({name, "_pop1"},  32'(bus.vc1_pop),    32'd0);
        check({name, "_count"}, 32'(bus.word_count), 32'd0);
    endtask

    // Asserts reset mid-cycle, checks it took effect without a clock edge,
    // and releases it so the next step() starts aligned.
    task automatic do_reset(input string name);
        #2 rst = 1'b0;
        #1 check_reset_values(name);
        bus.enable = 1'b0; bus.error_in = 1'b0;
        bus.d0_almost_full = 1'b0; bus.d1_almost_full = 1'b0;
        q0.delete(); q1.delete();
        drive_vc();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        m_state = 0; m_last = 1'b1; m_push0 = 1'b0; m_push1 = 1'b0;
        m_data = '0; m_count = 0;
        d0_log.delete(); d1_log.delete(); m_d0_log.delete(); m_d1_log.delete();
    endtask

    initial begin
        tbl[0] = '{0,0,0,0,0,0, 1,0,0,1,0};
        tbl[1] = '{0,0,0,0,0,0, 0,1,1,1,0};
        tbl[2] = '{1,0,0,0,0,0, 0,1,1,1,0};
        tbl[3] = '{0,0,1,0,0,1, 0,1,1,1,0};
        tbl[4] = '{0,0,1,1,0,1, 0,0,1,0,0};
        tbl[5] = '{0,0,1,0,1,0, 1,0,0,0,1};
        tbl[6] = '{1,1,0,0,0,0, 0,0,0,0,0};
        tbl[7] = '{0,0,1,1,1,0, 0,1,1,0,1};

        do_reset("reset0");

        // Grant decode table: one cycle in IDLE -> RUN, then one row per cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] exp_data;
            bus.vc0_empty      = tbl[i].e0;
            bus.vc1_empty      = tbl[i].e1;
            bus.vc0_data       = {tbl[i].m0, 5'h0A};
            bus.vc1_data       = {tbl[i].m1, 5'h15};
            bus.d0_almost_full = tbl[i].af0;
            bus.d1_almost_full = tbl[i].af1;
            exp_data = tbl[i].p0 ? {tbl[i].m0, 5'h0A} : {tbl[i].m1, 5'h15};
            #2;
            check($sformatf("tbl%0d_pop0", i), 32'(bus.vc0_pop), 32'(tbl[i].p0));
            check($sformatf("tbl%0d_pop1", i), 32'(bus.vc1_pop), 32'(tbl[i].p1));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_lg", i),    32'(bus.last_grant), 32'(tbl[i].lg));
            check($sformatf("tbl%0d_d0p", i),   32'(bus.d0_push),    32'(tbl[i].d0p));
            check($sformatf("tbl%0d_d1p", i),   32'(bus.d1_push),    32'(tbl[i].d1p));
            if (tbl[i].d0p || tbl[i].d1p)
                check($sformatf("tbl%0d_data", i), 32'(bus.d_data), 32'(exp_data));
        end

        // Strict alternation, three words per VC, all to D0.
        do_reset("reset1");
        q0 = '{6'd1, 6'd2, 6'd3};
        q1 = '{6'd9, 6'd10, 6'd11};
        drain(20);
        check("alt_count", 32'(bus.word_count), 32'd6);
        check("alt_len", 32'(d0_log.size()), 32'd6);
        if (d0_log.size() == 6) begin
            check("alt_w0", 32'(d0_log[0]), 32'd1);
            check("alt_w1", 32'(d0_log[1]), 32'd9);
            check("alt_w2", 32'(d0_log[2]), 32'd2);
            check("alt_w5", 32'(d0_log[5]), 32'd11);
        end

        // Head-of-line blocking on D1 while VC1 drains into D0.
        do_reset("reset2");
        q0 = '{6'b100000};
        q1 = '{6'd4, 6'd5, 6'd6};
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("hol_vc0_held", 32'(q0.size()), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("hol_vc0_popped", 32'(q0.size()), 32'd0);
        check("hol_d1_word", 32'(bus.d1_push ? bus.d_data : 6'd0), 32'(6'b100000));
        drain(10);
        compare_logs("hol");

        // Error while a grant is possible; prior push still completes.
        do_reset("reset3");
        q0 = '{6'd1, 6'd2, 6'd3, 6'd4};
        q1 = '{6'd9, 6'd10};
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("err_prior_push", 32'(bus.d0_push), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("err_halt", 32'(bus.state), 32'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("err_idle", 32'(bus.state), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("err_run", 32'(bus.state), 32'd1);
        drain(20);
        compare_logs("err");

        // enable low for two cycles mid-stream.
        do_reset("reset4");
        q0 = '{6'd1, 6'd2, 6'd3, 6'd4};
        q1 = '{6'd17, 6'd18, 6'd19, 6'd20};
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        drain(20);
        check("en_total", 32'(d0_log.size()), 32'd8);
        compare_logs("en");

        // 257 pushes wrap the counter to 1.
        do_reset("reset5");
        for (int i = 0; i < 257; i++) q0.push_back(DW'(i % 32));
        drain(300);
        check("wrap_count", 32'(bus.word_count), 32'd1);

        // Randomised traffic against the model.
        do_reset("reset6");
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 8 && $urandom_range(0, 2) != 0) q0.push_back(DW'($urandom_range(0, 63)));
            if (q1.size() < 8 && $urandom_range(0, 2) != 0) q1.push_back(DW'($urandom_range(0, 63)));
            step($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        drain(100);
        compare_logs("rand");

        // Asynchronous reset while a push is on the outputs.
        do_reset("reset7");
        q0 = '{6'd1, 6'd2, 6'd3, 6'd4};
        q1 = '{6'd5, 6'd6, 6'd7, 6'd8};
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_push_live", 32'(bus.d0_push), 32'd1);
        do_reset("midrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arbitro_vc.md
# arbitro_vc

Round-robin arbiter/router between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). It runs under the flow-control state machine: words move only while that FSM reports IDLE/ACTIVE and no error. Each granted word is popped from a first-word-fall-through VC FIFO and pushed one cycle later into the destination selected by the word's MSB, with back-pressure from destination almost-full thresholds.

## Interface
Parameters:
- DATA_WIDTH, 6, word width; bit DATA_WIDTH-1 is the destination select (0 = D0, 1 = D1)
- COUNT_WIDTH, 8, width of the transferred-word counter

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately, independent of clk
- enable  in  1  high when the flow-control FSM is in IDLE or ACTIVE
- error_in  in  1  error_out of the flow-control FSM
- vc0_empty, vc1_empty  in  1  VC FIFO empty flags
- vc0_data, vc1_data  in  DATA_WIDTH  FWFT head word, valid whenever the matching empty is 0
- d0_almost_full, d1_almost_full  in  1  destination threshold flags; must assert while free slots ≤ 2
- vc0_pop, vc1_pop  out  1  combinational pop strobes
- d0_push, d1_push  out  1  registered push strobes
- d_data  out  DATA_WIDTH  registered word for the destination FIFOs
- last_grant  out  1  VC granted most recently (0 = VC0, 1 = VC1)
- state  out  2  0 = IDLE, 1 = RUN, 2 = HALT
- word_count  out  COUNT_WIDTH  number of pushes performed, modulo 2^COUNT_WIDTH

## Operation
- Reset values: state = IDLE, last_grant = 1 (VC0 wins the first tie), d_data = 0, d0_push = d1_push = 0, word_count = 0. vc0_pop and vc1_pop are 0 while reset is low.
- Eligibility: VCn is eligible when vcn_empty = 0 and the almost_full flag of destination vcn_data[DATA_WIDTH-1] is 0.
- Grant: a grant is issued only when state = RUN, enable = 1 and error_in = 0.
  - Exactly one VC eligible: that VC is granted.
  - Both eligible: the VC not equal to last_grant is granted.
  - Neither eligible: no grant.
- At most one pop per cycle. The vcN_pop strobe is asserted in the same cycle as its grant.
- last_grant updates on the posedge following a grant and holds otherwise.
- Routing: on the posedge after a grant, d_data is loaded with the granted head word and exactly one of d0_push/d1_push is set according to its MSB. Without a grant both pushes are 0; d_data holds its value.
- word_count increments on every posedge at which d0_push or d1_push is 1. It wraps from all-ones to 0.
- FSM:
  - IDLE -> RUN when enable = 1 and error_in = 0.
  - RUN -> IDLE when enable = 0.
  - Any state -> HALT when error_in = 1; this has priority over all other transitions.
  - HALT -> IDLE when error_in = 0.
- Head-of-line blocking: a VC whose head targets a full destination stalls. The other VC keeps flowing if it is eligible.

## Timing
- Pop to push latency: 1 cycle. Pop in cycle N gives push and d_data valid in cycle N+1; word_count reflects that push in cycle N+2.
- Throughput: 1 word/cycle sustained. Strict alternation VC0/VC1 while both are eligible.
- enable or error_in dropping in cycle N suppresses pops in cycle N (combinational gating). A push already registered from cycle N-1 still completes in cycle N.
- The ≤ 2 free-slot almost-full rule covers one in-flight push plus one same-cycle pop; no overflow is possible.
- Reset asserted mid-transfer: any pending push is discarded at once and outputs return to reset values.

## Test plan
- Reset, then enable=1 with both VCs holding 3 words (all destination bits 0): pops follow VC0,VC1,VC0,VC1,VC0,VC1 on consecutive cycles. d0_push is high for 6 cycles, delayed one cycle. word_count = 6.
- VC0 head = 0b100000 with d1_almost_full = 1, and VC1 holding words to D0: VC0 never pops while VC1 drains. Releasing d1_almost_full lets VC0 pop the next cycle, and d1_push carries 0b100000.
- error_in = 1 in the same cycle as a grant-eligible condition: no pop that cycle and state = HALT next cycle. A push registered in the prior cycle still appears. error_in = 0 gives IDLE, then RUN.
- enable toggles low for 2 cycles in mid-stream: no pops in those cycles, state passes through IDLE, and no words are lost or duplicated (check the sequence in D0).
- Push 257 words: word_count wraps to 1.
- Assert reset asynchronously between clock edges during streaming: pushes, pops and word_count go to 0 immediately, and last_grant = 1.
